// File: rtl/ysyx_23060187_instfetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and hands the word to decode.
// Optional misaligned-redirect trap enabled by YSYX_23060187_FETCH_MISALIGN_CHECK_EN.
module ysyx_23060187_instfetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
  ,output logic       fetch_misalign
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_KILL,
    S_HOLD
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
    ,S_FAULT
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              req_valid_q, req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic [XLEN-1:0]   redir_tgt;
  logic              redir_bad;
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  // Next-state, PC and instruction-buffer update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    redir_tgt = redirect_pc & ~XLEN'(3);
    redir_bad = 1'b0;
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
    redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redir_tgt;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = imem_req_ready ? S_KILL : S_REQ;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = imem_rsp_valid ? S_REQ : S_KILL;
        end else if (imem_rsp_valid) begin
          inst_d    = imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end
      end
      S_KILL: begin
        // A redirect here only retargets; the abandoned response still has to drain.
        if (redirect_valid) pc_d = redir_tgt;
        if (imem_rsp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = XLEN'(pc_q + XLEN'(4));
          state_d = S_REQ;
        end
      end
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
    if (redir_bad && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
      pc_d    = pc_q;
    end
    misalign_d = (state_d == S_FAULT);
`endif

    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
`ifdef YSYX_23060187_FETCH_MISALIGN_CHECK_EN
  assign fetch_misalign = misalign_q;
`endif

endmodule

// File: doc/ysyx_23060187_instfetch.md
# ysyx_23060187_instFetch

Instruction fetch stage of the NPC core. Holds the PC, issues one instruction-memory read at a time over a valid/ready request channel, and registers the returned word for the instruction decoder. It redirects on jumps/branches from execute and stalls while decode withholds `inst_ready`.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  32  read address (= current PC).
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  read data valid (one-cycle pulse, exactly one per accepted request).
- `imem_rsp_data`  in  32  read data.
- `redirect_valid`  in  1  PC redirect request from execute.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction for decode.
- `inst`  out  32  fetched instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decode consumes instruction this cycle.
- `fetch_misalign`  out  1  sticky misaligned-redirect flag (present only with `YSYX_23060187_FETCH_MISALIGN_CHECK_EN`).

## Operation
- States: IDLE, REQ, WAIT, KILL, HOLD (plus FAULT with macro).
- IDLE: reset state; unconditionally → REQ next cycle.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. On `imem_req_ready` → WAIT; otherwise stay.
- WAIT: on `imem_rsp_valid`, latch `inst`<=`imem_rsp_data`, `inst_pc`<=pc → HOLD.
- HOLD: `inst_valid`=1. On `inst_ready`, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC → 0) → REQ.
- KILL: waits for the response of an abandoned request; on `imem_rsp_valid`, discard data → REQ.
- Redirect (`redirect_valid`=1), priority over every other event in the same cycle, pc<=`redirect_pc`:
  - IDLE/REQ without handshake/HOLD → REQ (HOLD instruction dropped, even if `inst_ready`=1 same cycle; no pc+4).
  - REQ with handshake same cycle → KILL.
  - WAIT without `imem_rsp_valid` → KILL; WAIT with `imem_rsp_valid` → REQ, data discarded.
  - KILL → stays KILL (pc updated; pending response still discarded).
- `imem_req_valid` and `inst_valid` are decoded from state only; `imem_req_addr` = pc register.
- `imem_rsp_valid` outside WAIT/KILL is ignored.
- At most one outstanding request.

## Timing
- Reset (async assert, any state): state=IDLE, pc=`RESET_PC`, `inst`=0, `inst_pc`=0, `imem_req_valid`=0, `inst_valid`=0, `fetch_misalign`=0. Reset mid-request abandons it; memory is reset together.
- First request visible cycle 1 after `rst_n` deassert edge.
- Response must arrive ≥1 cycle after request acceptance.
- Best case: REQ(ready) → WAIT(rsp) → HOLD(inst_ready): one instruction per 3 cycles; `inst_valid` rises the cycle after `imem_rsp_valid`.
- Redirect to first new request: next cycle (from REQ/HOLD/IDLE), or cycle after abandoned response (from KILL).
- `inst`/`inst_pc` stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration
- `YSYX_23060187_FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 enters FAULT (pc unchanged, outstanding response discarded if any); FAULT drives `imem_req_valid`=0, `inst_valid`=0, `fetch_misalign`=1 until reset; further redirects ignored.
- Undefined: `fetch_misalign` port absent; `redirect_pc[1:0]` ignored (pc<=`{redirect_pc[31:2],2'b00}`); no FAULT state.

## Test plan
- Reset, memory always ready, rsp 1 cycle later, `inst_ready`=1 -> addrs 0x80000000, 0x80000004, 0x80000008; `inst_valid` every 3rd cycle with matching `inst_pc`.
- `inst_ready`=0 for 5 cycles in HOLD -> `inst`/`inst_pc` stable, no new request, `imem_req_valid`=0.
- Redirect to 0x80001000 in the cycle the request to 0x80000004 is accepted -> response 0x00000013 discarded, next request 0x80001000, no `inst_valid` for 0x80000004.
- Redirect to 0x80000200 while HOLD with `inst_ready`=1 -> instruction dropped, next request 0x80000200 (not pc+4).
- Assert `rst_n`=0 while in WAIT -> outputs zero immediately; after release first request at 0x80000000.
- Macro on: redirect to 0x80000102 -> `fetch_misalign`=1 sticky, no further requests until reset; macro off: next request 0x80000100.
